// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : frame_sequencer
// Brief    : Wishbone-programmed exposure scheduler driving one signal_generator.
// Revision : 1.0
// ============================================================================
module frame_sequencer #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0100,
    parameter logic [31:0] TIMEOUT   = 32'd1_000_000
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    input  logic        i_phi_p,
    output logic        o_gen_enable,
    output logic [3:0]  o_gen_fsel,
    output logic        o_gen_clk,
    output logic        o_irq
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state_q;
    logic        wb_ack_q;
    logic [31:0] wb_rdata_q;
    logic [2:0]  phi_q;
    logic        loop_q, ie_done_q, ie_err_q;
    logic        done_q, error_q, aborted_q;
    logic [1:0]  idx_q;
    logic [15:0] left_q;
    logic [7:0]  div_q;
    logic [7:0]  divcnt_q;
    logic [19:0] entry_q [4];
    logic        enable_q, genclk_q;
    logic [3:0]  fsel_q;
    logic [31:0] wdog_q;

    logic [31:0] wb_off;
    logic        wb_hit, wb_req, wr;
    logic [2:0]  reg_sel;
    logic [1:0]  ent_sel, next_idx;
    logic        busy, start_wr, abort_wr;
    logic        phi_rise, phi_fall, wdog_expire, wrap_ok;
    logic [7:0]  div_eff;
    logic [31:0] rd_data;
    logic        unused_ok;

    assign wb_off   = i_wb_addr - BASE_ADDR;
    assign wb_hit   = (wb_off[31:5] == 27'd0) && (wb_off[1:0] == 2'b00);
    assign wb_req   = i_wb_cyc & i_wb_stb & wb_hit & ~wb_ack_q;
    assign wr       = wb_req & i_wb_we;
    assign reg_sel  = wb_off[4:2];
    // ENTRY0..3 sit at register slots 3..6; adding 1 mod 4 maps them to 0..3
    assign ent_sel  = reg_sel[1:0] + 2'd1;
    assign busy     = (state_q == ST_PRIME) || (state_q == ST_RUN);
    assign abort_wr = wr && (reg_sel == 3'd0) && i_wb_data[1];
    assign start_wr = wr && (reg_sel == 3'd0) && i_wb_data[0] && !i_wb_data[1];
    assign phi_rise = phi_q[1] & ~phi_q[2];
    assign phi_fall = ~phi_q[1] & phi_q[2];
    assign wdog_expire = busy && !(phi_rise || phi_fall) && (wdog_q == TIMEOUT - 32'd1);
    assign next_idx = idx_q + 2'd1;
    assign wrap_ok  = (idx_q != 2'd3) || loop_q;
    assign div_eff  = (div_q == 8'd0) ? 8'd1 : div_q;
    assign unused_ok = &{1'b0, i_wb_data[31:20]};

    always_comb begin
        rd_data = 32'd0;
        case (reg_sel)
            3'd0: rd_data = {27'd0, ie_err_q, ie_done_q, loop_q, 2'b00};
            3'd1: rd_data = {8'd0, left_q, 2'b00, idx_q, aborted_q, error_q, done_q, busy};
            3'd2: rd_data = {24'd0, div_q};
            3'd3, 3'd4, 3'd5, 3'd6: rd_data = {12'd0, entry_q[ent_sel]};
            default: rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state_q    <= ST_IDLE;
            wb_ack_q   <= 1'b0;
            wb_rdata_q <= 32'd0;
            phi_q      <= 3'd0;
            loop_q     <= 1'b0;
            ie_done_q  <= 1'b0;
            ie_err_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            aborted_q  <= 1'b0;
            idx_q      <= 2'd0;
            left_q     <= 16'd0;
            div_q      <= 8'd1;
            divcnt_q   <= 8'd0;
            for (int i = 0; i < 4; i++) entry_q[i] <= 20'd0;
            enable_q   <= 1'b0;
            genclk_q   <= 1'b0;
            fsel_q     <= 4'd0;
            wdog_q     <= 32'd0;
        end else begin
            phi_q      <= {phi_q[1:0], i_phi_p};
            wb_ack_q   <= wb_req;
            wb_rdata_q <= wb_req ? rd_data : 32'd0;

            if (wr && (reg_sel == 3'd0)) begin
                {ie_err_q, ie_done_q, loop_q} <= i_wb_data[4:2];
            end
            if (wr && !busy) begin
                if (reg_sel == 3'd2) div_q <= i_wb_data[7:0];
                if ((reg_sel >= 3'd3) && (reg_sel <= 3'd6)) entry_q[ent_sel] <= i_wb_data[19:0];
            end

            if (busy) begin
                if (divcnt_q >= div_eff - 8'd1) begin
                    genclk_q <= ~genclk_q;
                    divcnt_q <= 8'd0;
                end else begin
                    divcnt_q <= divcnt_q + 8'd1;
                end
                wdog_q <= (phi_rise || phi_fall) ? 32'd0 : wdog_q + 32'd1;
            end else begin
                wdog_q <= 32'd0;
            end

            // Later assignments below override the free-running divider/watchdog
            if (abort_wr) begin
                state_q   <= ST_IDLE;
                enable_q  <= 1'b0;
                genclk_q  <= 1'b0;
                aborted_q <= 1'b1;
            end else if (wdog_expire) begin
                state_q  <= ST_IDLE;
                enable_q <= 1'b0;
                genclk_q <= 1'b0;
                error_q  <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_wr) begin
                            done_q    <= 1'b0;
                            error_q   <= 1'b0;
                            aborted_q <= 1'b0;
                            if (entry_q[0][19:4] == 16'd0) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q  <= ST_PRIME;
                                enable_q <= 1'b1;
                                fsel_q   <= entry_q[0][3:0];
                                idx_q    <= 2'd0;
                                left_q   <= entry_q[0][19:4];
                                divcnt_q <= 8'd0;
                                genclk_q <= 1'b0;
                            end
                        end
                    end
                    ST_PRIME: begin
                        if (phi_fall) state_q <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (phi_rise) begin
                            if (left_q > 16'd1) begin
                                left_q <= left_q - 16'd1;
                            end else if (wrap_ok && (entry_q[next_idx][19:4] != 16'd0)) begin
                                idx_q  <= next_idx;
                                fsel_q <= entry_q[next_idx][3:0];
                                left_q <= entry_q[next_idx][19:4];
                            end else begin
                                state_q  <= ST_DONE;
                                enable_q <= 1'b0;
                                genclk_q <= 1'b0;
                                left_q   <= 16'd0;
                                done_q   <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_wb_ack     = wb_ack_q;
    assign o_wb_data    = wb_rdata_q;
    assign o_gen_enable = enable_q;
    assign o_gen_fsel   = fsel_q;
    assign o_gen_clk    = genclk_q;
    assign o_irq        = (done_q & ie_done_q) | (error_q & ie_err_q);

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_sequencer
// Brief    : Directed self-checking bench for frame_sequencer.
// Revision : 1.0
// ============================================================================
module tb_frame_sequencer;

    localparam logic [31:0] C_BASE = 32'h3000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic        ack;
    logic [31:0] rdata;
    logic        phi = 1'b0;
    logic        gen_en, gen_clk, irq;
    logic [3:0]  gen_fsel;

    int n_checks = 0;
    int n_errors = 0;

    frame_sequencer #(.BASE_ADDR(C_BASE), .TIMEOUT(32'd100)) dut (
        .i_wb_clk    (clk),
        .i_wb_rst_n  (rst_n),
        .i_wb_cyc    (cyc),
        .i_wb_stb    (stb),
        .i_wb_we     (we),
        .i_wb_addr   (addr),
        .i_wb_data   (wdata),
        .o_wb_ack    (ack),
        .o_wb_data   (rdata),
        .i_phi_p     (phi),
        .o_gen_enable(gen_en),
        .o_gen_fsel  (gen_fsel),
        .o_gen_clk   (gen_clk),
        .o_irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_access(input logic is_wr, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] q, output logic acked);
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = is_wr; addr = a; wdata = d;
        acked = 1'b0; q = 32'd0;
        for (int i = 0; i < 4 && !acked; i++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                acked = 1'b1;
                q = rdata;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] off, input logic [31:0] d);
        logic [31:0] q;
        logic        a;
        wb_access(1'b1, C_BASE + off, d, q, a);
        if (!a) check_eq("write_ack", {31'd0, a}, 32'd1);
    endtask

    task automatic wb_read(input logic [31:0] off, output logic [31:0] q);
        logic a;
        wb_access(1'b0, C_BASE + off, 32'd0, q, a);
        if (!a) check_eq("read_ack", {31'd0, a}, 32'd1);
    endtask

    task automatic phi_pulse();
        phi = 1'b1; tick(6);
        phi = 1'b0; tick(6);
    endtask

    task automatic wait_enable_low(input int max_cyc, output int n);
        n = 0;
        while (gen_en && n < max_cyc) begin
            tick(1);
            n++;
        end
    endtask

    task automatic count_toggles(input int window, output int n);
        logic prev;
        n = 0;
        prev = gen_clk;
        for (int i = 0; i < window; i++) begin
            tick(1);
            if (gen_clk !== prev) n++;
            prev = gen_clk;
        end
    endtask

    logic [31:0] rd;
    logic        acked;
    int          n;
    logic [3:0]  fsels [4];

    initial begin
        fsels[0] = 4'd3; fsels[1] = 4'd4; fsels[2] = 4'd6; fsels[3] = 4'd7;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Reset state
        check_eq("rst_enable", {31'd0, gen_en}, 32'd0);
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
        wb_read(32'h04, rd); check_eq("rst_status", rd, 32'd0);
        wb_read(32'h08, rd); check_eq("rst_div", rd, 32'd1);

        // Single entry, three frames
        wb_write(32'h08, 32'd2);
        wb_write(32'h0C, 32'h0000_0032);
        wb_write(32'h10, 32'd0);
        wb_write(32'h00, 32'h0000_0009);
        check_eq("t2_enable", {31'd0, gen_en}, 32'd1);
        check_eq("t2_fsel", {28'd0, gen_fsel}, 32'd2);
        wb_read(32'h04, rd); check_eq("t2_status_prime", rd, 32'h0000_0301);
        count_toggles(16, n); check_eq("t2_genclk_div2", n, 32'd8);
        phi_pulse();
        phi_pulse();
        wb_read(32'h04, rd); check_eq("t2_status_left2", rd, 32'h0000_0201);
        phi_pulse();
        phi = 1'b1;
        wait_enable_low(8, n);
        check_eq("t2_enable_drop_window", {31'd0, (n >= 2 && n <= 4)}, 32'd1);
        phi = 1'b0; tick(4);
        check_eq("t2_genclk_low", {31'd0, gen_clk}, 32'd0);
        wb_read(32'h04, rd); check_eq("t2_status_done", rd & 32'h3F, 32'h02);
        check_eq("t2_irq", {31'd0, irq}, 32'd1);

        // Two entries: fsel switch on the second rise
        wb_write(32'h0C, 32'h0000_0021);
        wb_write(32'h10, 32'h0000_0015);
        wb_write(32'h14, 32'd0);
        wb_write(32'h00, 32'h0000_0001);
        check_eq("t3_irq_cleared", {31'd0, irq}, 32'd0);
        check_eq("t3_fsel0", {28'd0, gen_fsel}, 32'd1);
        phi_pulse();
        phi_pulse();
        phi = 1'b1;
        n = 0;
        while (gen_fsel != 4'd5 && n < 6) begin tick(1); n++; end
        check_eq("t3_fsel1", {28'd0, gen_fsel}, 32'd5);
        wb_read(32'h04, rd); check_eq("t3_status_idx1", rd, 32'h0000_0111);
        phi = 1'b0; tick(6);
        phi = 1'b1;
        wait_enable_low(8, n);
        check_eq("t3_enable_drop", {31'd0, gen_en}, 32'd0);
        phi = 1'b0; tick(4);
        wb_read(32'h04, rd); check_eq("t3_status_done", rd & 32'h3F, 32'h12);
        check_eq("t3_irq_masked", {31'd0, irq}, 32'd0);

        // Looping table, then abort
        for (int i = 0; i < 4; i++) wb_write(32'h0C + 32'(4 * i), {28'h000_0001, fsels[i]});
        wb_write(32'h00, 32'h0000_0005);
        phi_pulse();
        for (int k = 1; k <= 6; k++) begin
            phi_pulse();
            wb_read(32'h04, rd);
            check_eq($sformatf("t4_idx_%0d", k), (rd >> 4) & 32'h3, 32'(k % 4));
            check_eq($sformatf("t4_fsel_%0d", k), {28'd0, gen_fsel}, {28'd0, fsels[k % 4]});
        end
        wb_write(32'h00, 32'h0000_0006);
        check_eq("t4_abort_enable", {31'd0, gen_en}, 32'd0);
        check_eq("t4_abort_genclk", {31'd0, gen_clk}, 32'd0);
        wb_read(32'h04, rd); check_eq("t4_status_abort", rd & 32'hF, 32'h8);

        // Watchdog: phi stuck high
        wb_write(32'h00, 32'h0000_0011);
        check_eq("t5_enable", {31'd0, gen_en}, 32'd1);
        phi = 1'b1;
        wait_enable_low(150, n);
        check_eq("t5_timeout_window", {31'd0, (n >= 95 && n <= 110)}, 32'd1);
        wb_read(32'h04, rd); check_eq("t5_status_error", rd & 32'hF, 32'h4);
        check_eq("t5_irq", {31'd0, irq}, 32'd1);
        phi = 1'b0; tick(4);

        // Bus corner cases
        wb_read(32'h1C, rd); check_eq("t6_reserved", rd, 32'd0);
        wb_access(1'b0, 32'h3000_0120, 32'd0, rd, acked);
        check_eq("t6_noack_out_of_range", {31'd0, acked}, 32'd0);
        wb_write(32'h00, 32'h0000_0001);
        wb_write(32'h08, 32'd5);
        wb_read(32'h08, rd); check_eq("t6_div_locked", rd, 32'd2);
        wb_write(32'h00, 32'h0000_0002);

        // DIV=0 behaves as 1, then async reset mid-run
        wb_write(32'h08, 32'd0);
        wb_write(32'h0C, 32'h0000_0032);
        wb_write(32'h00, 32'h0000_0001);
        count_toggles(16, n); check_eq("t1_genclk_div0", n, 32'd16);
        phi_pulse();
        check_eq("t1_running", {31'd0, gen_en}, 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t1_async_enable", {31'd0, gen_en}, 32'd0);
        check_eq("t1_async_genclk", {31'd0, gen_clk}, 32'd0);
        check_eq("t1_async_ack", {31'd0, ack}, 32'd0);
        check_eq("t1_async_irq", {31'd0, irq}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        wb_read(32'h04, rd); check_eq("t1_status_after_rst", rd, 32'd0);
        wb_read(32'h08, rd); check_eq("t1_div_after_rst", rd, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
